// File: rtl/pwm_sample_out.sv
`default_nettype none
//==============================================================================
// Module      : pwm_sample_out
// Description : Audio PWM output stage. Samples arrive over a valid/ready
//               handshake into a small FIFO; each PWM period of 2**SAMPLE_W
//               clocks pops one sample and uses it as the duty (number of
//               high cycles at the start of the period) on output D.
// Ports       : clk           - system clock
//               nrst          - asynchronous active-low reset
//               en            - output enable (low: idle, D held low)
//               sample_in     - unsigned duty value
//               sample_valid  - producer has a sample on sample_in
//               sample_ready  - FIFO has room (from registered level only)
//               D             - PWM output (registered)
//               period_strobe - 1-cycle pulse in the first cycle of a period
//               underrun      - 1-cycle pulse: period started with FIFO empty
//               fifo_level    - number of buffered samples
// Revision    : 1.0 - initial release
//==============================================================================
module pwm_sample_out #(
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             en,
    input  logic [SAMPLE_W-1:0]              sample_in,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    output logic                             D,
    output logic                             period_strobe,
    output logic                             underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [SAMPLE_W-1:0] c_CNT_MAX = '1;
    localparam logic [LVL_W-1:0]    c_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]    c_EMPTY   = '0;

    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [SAMPLE_W-1:0] r_cnt;
    logic [SAMPLE_W-1:0] r_duty;
    logic                r_d;
    logic                r_strobe;
    logic                r_underrun;

    logic                w_push;
    logic                w_wrap;
    logic                w_pop;
    logic [SAMPLE_W-1:0] w_cnt_next;
    logic [SAMPLE_W-1:0] w_duty_next;
    logic [LVL_W-1:0]    w_level_next;

    // Ready depends only on the registered level, so no combinational path
    // runs from sample_valid back to sample_ready.
    assign sample_ready  = (r_level < c_FULL);
    assign fifo_level    = r_level;
    assign D             = r_d;
    assign period_strobe = r_strobe;
    assign underrun      = r_underrun;

    assign w_push = sample_valid && sample_ready;
    // The period boundary is the edge on which the counter sits at its
    // maximum with the output enabled; while disabled the counter is parked
    // at the maximum so re-enabling starts a fresh period on the next edge.
    assign w_wrap = en && (r_cnt == c_CNT_MAX);
    // Pop decision uses the pre-edge level: a sample pushed on the same edge
    // as an empty-FIFO wrap is not visible until the following period.
    assign w_pop  = w_wrap && (r_level != c_EMPTY);

    always_comb begin
        w_cnt_next   = c_CNT_MAX;
        w_duty_next  = '0;
        w_level_next = r_level;

        if (en) begin
            // Unsigned overflow takes the counter from maximum back to 0.
            w_cnt_next  = r_cnt + 1'b1;
            w_duty_next = w_pop ? r_mem[r_rd_ptr] : r_duty;
        end

        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Storage carries no reset: emptiness is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_cnt      <= c_CNT_MAX;
            r_duty     <= '0;
            r_d        <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_next;
            r_cnt      <= w_cnt_next;
            r_duty     <= w_duty_next;
            // Output is high while the upcoming count is below the duty, so
            // a duty of all-ones still leaves the final cycle of the period low.
            r_d        <= en && (w_cnt_next < w_duty_next);
            r_strobe   <= w_wrap;
            r_underrun <= w_wrap && (r_level == c_EMPTY);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_sample_out.sv
`default_nettype none
//==============================================================================
// Module      : tb_pwm_sample_out
// Description : Randomized self-checking bench for pwm_sample_out. A queue
//               based reference model tracks the buffered samples, the
//               position inside the current PWM period and the active duty,
//               and predicts every output each clock.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pwm_sample_out;

    localparam int SAMPLE_W   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PERIOD     = 1 << SAMPLE_W;
    localparam int IDLE_POS   = PERIOD - 1;

    logic                tb_clk = 1'b0;
    logic                nrst;
    logic                en;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic                D;
    logic                period_strobe;
    logic                underrun;
    logic [2:0]          fifo_level;

    pwm_sample_out #(
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (tb_clk),
        .nrst          (nrst),
        .en            (en),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .D             (D),
        .period_strobe (period_strobe),
        .underrun      (underrun),
        .fifo_level    (fifo_level)
    );

    always #50 tb_clk = ~tb_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int q[$];
    int pos;          // position within the current period; IDLE_POS when parked
    int duty_m;
    bit exp_d;
    bit exp_stb;
    bit exp_und;
    bit last_accept;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos         = IDLE_POS;
        duty_m      = 0;
        exp_d       = 1'b0;
        exp_stb     = 1'b0;
        exp_und     = 1'b0;
        last_accept = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_step();
        int pre_size;
        pre_size    = q.size();
        last_accept = sample_valid && (pre_size < FIFO_DEPTH);
        exp_stb     = 1'b0;
        exp_und     = 1'b0;
        if (!en) begin
            pos    = IDLE_POS;
            duty_m = 0;
        end else if (pos == IDLE_POS) begin
            pos     = 0;
            exp_stb = 1'b1;
            if (pre_size > 0) duty_m = q.pop_front();
            else              exp_und = 1'b1;
        end else begin
            pos = pos + 1;
        end
        if (last_accept) q.push_back(int'(sample_in));
        exp_d = en && (pos < duty_m);
    endtask

    task automatic check_all();
        check_val("D",             32'(D),             32'(exp_d));
        check_val("period_strobe", 32'(period_strobe), 32'(exp_stb));
        check_val("underrun",      32'(underrun),      32'(exp_und));
        check_val("fifo_level",    32'(fifo_level),    32'(q.size()));
        check_val("sample_ready",  32'(sample_ready),  32'(q.size() < FIFO_DEPTH));
    endtask

    function automatic logic [SAMPLE_W-1:0] pick_sample();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return 8'd1;
            3:       return 8'd254;
            default: return 8'($urandom_range(PERIOD - 1));
        endcase
    endfunction

    // mode 0: random valid at valid_pct; mode 1: push only just before a wrap
    // edge with an empty FIFO (push/pop collision).
    task automatic run_segment(input int cycles, input int en_div, input int valid_pct, input int mode);
        for (int c = 0; c < cycles; c++) begin
            if (en_div != 0 && $urandom_range(en_div - 1) == 0) en = ~en;
            if (!(sample_valid && !last_accept)) begin
                if (mode == 1)
                    sample_valid = en && (pos == IDLE_POS) && (q.size() == 0);
                else
                    sample_valid = ($urandom_range(99) < valid_pct);
                sample_in = pick_sample();
            end
            @(posedge tb_clk);
            model_step();
            @(negedge tb_clk);
            check_all();
        end
    endtask

    initial begin
        nrst         = 1'b0;
        en           = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        model_reset();
        repeat (3) @(negedge tb_clk);
        nrst = 1'b1;
        check_all();

        // Sparse producer: underruns, held duty, enable drops mid-period.
        run_segment(3000, 1500, 1, 0);
        // Fast producer with enable on: FIFO fills, backpressure, ready reopening.
        en = 1'b1;
        run_segment(3000, 0, 60, 0);
        // Push exactly on empty-FIFO wrap edges.
        en = 1'b1;
        run_segment(2000, 0, 0, 1);
        // Frequent enable toggling.
        run_segment(4000, 120, 15, 0);

        // Asynchronous reset mid-period with buffered samples.
        en = 1'b1;
        run_segment(400, 0, 100, 0);
        #20;
        nrst         = 1'b0;
        sample_valid = 1'b0;
        #5;
        model_reset();
        check_all();
        @(posedge tb_clk);
        @(negedge tb_clk);
        nrst = 1'b1;
        check_all();

        // Fill while disabled, then enable and drain.
        en = 1'b0;
        run_segment(10, 0, 100, 0);
        check_val("full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
        en = 1'b1;
        run_segment(2000, 0, 30, 0);
        run_segment(2000, 300, 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
